pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the fetch / decode / execute front end.
- Generates enable and flush strobes for the IF/ID register, the decode-to-execute latch and the EX/MEM latch.
- Handles three cases: load-use hazards (bubble insertion), taken jumps (multi-cycle flush) and memory back-pressure (full freeze).
- Keeps saturating performance counters of stall cycles and flush events.

Parameters:
- REG_W, 6: register selector width (selA/selOut space); selB is REG_W-1 bits, zero-extended for compares.
- LOAD_STALL, 1: bubble cycles inserted per load-use hazard, range 1..7.
- FLUSH_CYCLES, 2: cycles the decode latch is flushed after a taken jump, range 1..7.
- CNT_W, 16: performance counter width.

Ports:
- clk in 1: clock.
- reset in 1: reset, synchronous, active-high.
- dec_valid in 1: decode stage holds a valid instruction.
- dec_selA in REG_W: decode source A selector.
- dec_selB in REG_W-1: decode source B selector.
- dec_uses_a in 1: decode instruction reads A.
- dec_uses_b in 1: decode instruction reads B (0 when the immediate is selected).
- ex_valid in 1: execute stage holds a valid instruction.
- ex_is_load in 1: execute instruction is a load.
- ex_selOut in REG_W: execute destination selector.
- jmp_taken in 1: jump resolved taken in execute, single-cycle strobe.
- mem_busy in 1: memory stage cannot accept; level signal.
- fetch_en out 1: PC and IF/ID load enable.
- ifid_flush out 1: IF/ID synchronous clear.
- decl_en out 1: decode latch enable.
- decl_flush out 1: decode latch synchronous clear (bubble).
- exl_en out 1: EX/MEM latch enable.
- state_o out 2: current state, for debug.
- stall_cnt out CNT_W: stall cycles, saturating.
- flush_cnt out CNT_W: taken-jump flush events, saturating.

Behaviour:
- States: RUN=0, LSTALL=1, FLUSH=2, FREEZE=3.
- Registered: state, remaining-cycle counter rc (3 bits), resume state, counters. Strobe outputs are combinational from state and inputs so a hazard acts in the same cycle.
- Reset:
  - State goes to RUN, rc=0, stall_cnt=0, flush_cnt=0.
  - While reset is high: fetch_en=0, decl_en=0, exl_en=0, ifid_flush=1, decl_flush=1.
  - Reset mid-stall or mid-flush aborts the operation immediately.
- Hazard condition hz is true when all of the following hold:
  - dec_valid, ex_valid and ex_is_load are 1;
  - ex_selOut != 0 (register 0 never hazards);
  - (dec_uses_a and dec_selA==ex_selOut) or (dec_uses_b and {0,dec_selB}==ex_selOut).
- Priority, evaluated every cycle in every state: mem_busy > jmp_taken > state-continuation > hz.
- mem_busy=1:
  - All enables 0 and both flushes 0. Nothing moves.
  - Entering FREEZE saves the prior state; rc holds.
  - stall_cnt increments.
  - When mem_busy drops, return to the saved state the next cycle.
- jmp_taken=1 with mem_busy=0:
  - fetch_en=1 (PC loads the target), ifid_flush=1, decl_flush=1, exl_en=1.
  - flush_cnt increments.
  - If FLUSH_CYCLES>1: go to FLUSH with rc=FLUSH_CYCLES-1; otherwise stay in RUN.
  - This cancels any LSTALL in progress.
- FLUSH:
  - fetch_en=1, decl_flush=1, exl_en=1; rc decrements each cycle.
  - When rc==1, go to RUN the next cycle.
  - A new jmp_taken in FLUSH restarts the flush and increments flush_cnt.
- RUN with hz:
  - fetch_en=0, decl_en=0, decl_flush=1 (bubble), exl_en=1.
  - stall_cnt increments.
  - If LOAD_STALL>1: go to LSTALL with rc=LOAD_STALL-1.
- LSTALL:
  - Same strobes as the RUN-with-hz case. rc decrements; at rc==1 go to RUN.
  - hz is re-evaluated in RUN, so a chained hazard stalls again.
- RUN, no event: fetch_en=1, decl_en=1, exl_en=1, flushes 0.
- decl_en and decl_flush are never both 1 unless reset is high.
- Counters saturate at all-ones. No wrap.

Test Plan:
- Reset held for 3 cycles, then released with no events -> during reset flushes=1 and enables=0; cycle 1 after release fetch_en=decl_en=exl_en=1, state_o=0, counters=0.
- ex_is_load=1, ex_selOut=5, dec_selA=5, dec_uses_a=1, LOAD_STALL=1 -> one cycle with fetch_en=0 and decl_flush=1, stall_cnt=1, RUN the next cycle. Repeat with ex_selOut=0 -> no stall.
- Hazard via B: dec_selB=5, dec_uses_b=0 -> no stall. With dec_uses_b=1 -> stall.
- jmp_taken pulse, FLUSH_CYCLES=2 -> decl_flush=1 for 2 cycles, ifid_flush=1 in cycle 1 only, flush_cnt=1, state sequence RUN→FLUSH→RUN.
- mem_busy high for 4 cycles during FLUSH (rc=1) -> all strobes 0, stall_cnt+=4, then one remaining flush cycle, then RUN.
- jmp_taken and hz in the same cycle -> jump strobes only, stall_cnt unchanged. Force the counters to all-ones -> they hold at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Front-end pipeline sequencer: load-use bubbles, jump flushes,
//            memory freeze, and saturating stall/flush event counters.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_W        = 6,
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_selA,
    input  logic [REG_W-2:0] dec_selB,
    input  logic             dec_uses_a,
    input  logic             dec_uses_b,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_selOut,
    input  logic             jmp_taken,
    input  logic             mem_busy,
    output logic             fetch_en,
    output logic             ifid_flush,
    output logic             decl_en,
    output logic             decl_flush,
    output logic             exl_en,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_FREEZE = 2'd3
    } state_t;

    localparam logic [2:0]       C_LOAD_RC  = 3'(LOAD_STALL - 1);
    localparam logic [2:0]       C_FLUSH_RC = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    state_t           r_state;
    state_t           r_resume;
    logic [2:0]       r_rc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [REG_W-1:0] w_sel_b_ext;
    logic             w_hz;
    logic             w_stall_inc;
    logic             w_flush_inc;

    assign w_sel_b_ext = {1'b0, dec_selB};

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign w_hz = dec_valid && ex_valid && ex_is_load && (ex_selOut != '0) &&
                  ((dec_uses_a && (dec_selA == ex_selOut)) ||
                   (dec_uses_b && (w_sel_b_ext == ex_selOut)));

    always_comb begin
        fetch_en    = 1'b0;
        ifid_flush  = 1'b0;
        decl_en     = 1'b0;
        decl_flush  = 1'b0;
        exl_en      = 1'b0;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        if (reset) begin
            ifid_flush = 1'b1;
            decl_flush = 1'b1;
        end else if (mem_busy) begin
            w_stall_inc = 1'b1;
        end else if (jmp_taken) begin
            fetch_en    = 1'b1;
            ifid_flush  = 1'b1;
            decl_flush  = 1'b1;
            exl_en      = 1'b1;
            w_flush_inc = 1'b1;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    fetch_en   = 1'b1;
                    decl_flush = 1'b1;
                    exl_en     = 1'b1;
                end
                ST_LSTALL: begin
                    decl_flush  = 1'b1;
                    exl_en      = 1'b1;
                    w_stall_inc = 1'b1;
                end
                ST_RUN: begin
                    if (w_hz) begin
                        decl_flush  = 1'b1;
                        exl_en      = 1'b1;
                        w_stall_inc = 1'b1;
                    end else begin
                        fetch_en = 1'b1;
                        decl_en  = 1'b1;
                        exl_en   = 1'b1;
                    end
                end
                default: ; // freeze exit cycle: pipeline stays parked one more cycle
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_resume    <= ST_RUN;
            r_rc        <= 3'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != C_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush_inc && (r_flush_cnt != C_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);

            if (mem_busy) begin
                // Only the first frozen cycle captures where to resume.
                if (r_state != ST_FREEZE)
                    r_resume <= r_state;
                r_state <= ST_FREEZE;
            end else if (jmp_taken) begin
                if (FLUSH_CYCLES > 1) begin
                    r_state <= ST_FLUSH;
                    r_rc    <= C_FLUSH_RC;
                end else begin
                    r_state <= ST_RUN;
                    r_rc    <= 3'd0;
                end
            end else begin
                case (r_state)
                    ST_FREEZE: r_state <= r_resume;
                    ST_FLUSH, ST_LSTALL: begin
                        r_rc <= r_rc - 3'd1;
                        if (r_rc <= 3'd1)
                            r_state <= ST_RUN;
                    end
                    default: begin
                        if (w_hz && (LOAD_STALL > 1)) begin
                            r_state <= ST_LSTALL;
                            r_rc    <= C_LOAD_RC;
                        end
                    end
                endcase
            end
        end
    end

    assign state_o   = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire
